// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the CPU data port.
// Accepts one load/store at a time, waits LATENCY cycles, then pulses ack.
// Optional store log (last_wadr/last_wdata/wr_count) enabled by the macro
// DMEM_WRITE_LOG_EN; when undefined those outputs are tied to zero.
module dmem_responder #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        ack,
  output logic [31:0] readdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] last_wadr,
  output logic [31:0] last_wdata,
  output logic [15:0] wr_count
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            cap_we_q, cap_we_d;
  logic            cap_err_q, cap_err_d;
  logic [AW-1:0]   cap_idx_q, cap_idx_d;
  logic [31:0]     cap_wdata_q, cap_wdata_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            commit_c;

  logic [31:0]     mem [DEPTH];

  // Misaligned or beyond the last word; full 32-bit compare, no aliasing.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (32'(a[31:2]) >= 32'(DEPTH));
  endfunction

  // A store commits on the edge that leaves RESP, only when error-free.
  assign commit_c = (state_q == S_RESP) && cap_we_q && !cap_err_q;

  // State, counter, capture and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      cap_we_q    <= 1'b0;
      cap_err_q   <= 1'b0;
      cap_idx_q   <= '0;
      cap_wdata_q <= 32'd0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_we_q    <= cap_we_d;
      cap_err_q   <= cap_err_d;
      cap_idx_q   <= cap_idx_d;
      cap_wdata_q <= cap_wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state, capture and response decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_we_d    = cap_we_q;
    cap_err_d   = cap_err_q;
    cap_idx_d   = cap_idx_q;
    cap_wdata_d = cap_wdata_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          cap_we_d    = memwrite;
          cap_err_d   = addr_bad(dataadr);
          cap_idx_d   = dataadr[AW+1:2];
          cap_wdata_d = writedata;
          cnt_d       = LAT;
          state_d     = (LAT != 4'd0) ? S_BUSY : S_RESP;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response fields are registered on entry to RESP.
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      ack_d = 1'b1;
      err_d = cap_err_d;
      if (!cap_we_d && !cap_err_d) begin
        rdata_d = mem[cap_idx_d];
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign readdata = rdata_q;

  // Word RAM, optionally cleared by reset.
  generate
    if (INIT_ZERO != 0) begin : g_mem_rst
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'd0;
          end
        end else if (commit_c) begin
          mem[cap_idx_q] <= cap_wdata_q;
        end
      end
    end else begin : g_mem_norst
      always_ff @(posedge clk) begin
        if (commit_c) begin
          mem[cap_idx_q] <= cap_wdata_q;
        end
      end
    end
  endgenerate

`ifdef DMEM_WRITE_LOG_EN
  logic [31:0] log_wadr_q;
  logic [31:0] log_wdata_q;
  logic [15:0] log_cnt_q;

  // Store log updated on each committed store; count saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      log_wadr_q  <= 32'd0;
      log_wdata_q <= 32'd0;
      log_cnt_q   <= 16'd0;
    end else if (commit_c) begin
      log_wadr_q  <= 32'({cap_idx_q, 2'b00});
      log_wdata_q <= cap_wdata_q;
      if (log_cnt_q != 16'hFFFF) begin
        log_cnt_q <= log_cnt_q + 16'd1;
      end
    end
  end

  assign last_wadr  = log_wadr_q;
  assign last_wdata = log_wdata_q;
  assign wr_count   = log_cnt_q;
`else
  assign last_wadr  = 32'd0;
  assign last_wdata = 32'd0;
  assign wr_count   = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (default parameters).
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic        ack;
  logic [31:0] readdata;
  logic        err;
  logic        busy;
  logic [31:0] last_wadr;
  logic [31:0] last_wdata;
  logic [15:0] wr_count;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .INIT_ZERO(1)) dut (
    .clk(clk), .rst(rst), .req(req), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .ack(ack),
    .readdata(readdata), .err(err), .busy(busy),
    .last_wadr(last_wadr), .last_wdata(last_wdata), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  logic [31:0] m_wadr;
  logic [31:0] m_wdata;
  int          m_cnt;
  int          total = 0;
  int          bad = 0;

  function automatic logic exp_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'(4 * DEPTH - 4));
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    m_wadr  = 32'd0;
    m_wdata = 32'd0;
    m_cnt   = 0;
  endtask

  // Drive a request (caller sits at a negedge) and push its expectation.
  task automatic start_req(input logic we, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic [5:0] idx;
    idx     = a[7:2];
    e.we    = we;
    e.adr   = a;
    e.wd    = wd;
    e.err   = exp_bad(a);
    e.rdata = (we || e.err) ? 32'd0 : model[idx];
    sb.push_back(e);
    req       = 1'b1;
    memwrite  = we;
    dataadr   = a;
    writedata = wd;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ack && cyc < 40);
    if (!ack) begin
      total++; bad++;
      $display("FAIL ack_timeout: got ack=%b after %0d cycles want 1", ack, cyc);
    end
  endtask

  // Pop the expectation and compare the response currently on the outputs.
  task automatic finish_resp(input int cyc, input logic drop_req);
    exp_t e;
    logic [5:0] idx;
    e = sb.pop_front();
    total++;
    if (cyc !== int'(LAT + 1)) begin
      bad++; $display("FAIL latency adr=%0h: got %0d want %0d", e.adr, cyc, LAT + 1);
    end
    total++;
    if (err !== e.err) begin
      bad++; $display("FAIL err adr=%0h: got %b want %b", e.adr, err, e.err);
    end
    total++;
    if (readdata !== e.rdata) begin
      bad++; $display("FAIL readdata adr=%0h: got %0h want %0h", e.adr, readdata, e.rdata);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL busy_at_ack: got %b want 1", busy);
    end
    if (drop_req) req = 1'b0;
    if (e.we && !e.err) begin
      idx = e.adr[7:2];
      model[idx] = e.wd;
      m_wadr  = e.adr;
      m_wdata = e.wd;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int c;
    @(negedge clk);
    start_req(we, a, wd);
    wait_ack(c);
    finish_resp(c, 1'b1);
  endtask

  task automatic check_log(input string tag);
`ifdef DMEM_WRITE_LOG_EN
    total++;
    if (last_wadr !== m_wadr) begin
      bad++; $display("FAIL %s last_wadr: got %0h want %0h", tag, last_wadr, m_wadr);
    end
    total++;
    if (last_wdata !== m_wdata) begin
      bad++; $display("FAIL %s last_wdata: got %0h want %0h", tag, last_wdata, m_wdata);
    end
    total++;
    if (wr_count !== 16'(m_cnt)) begin
      bad++; $display("FAIL %s wr_count: got %0d want %0d", tag, wr_count, m_cnt);
    end
`else
    total++;
    if ({last_wadr, last_wdata, wr_count} !== 80'd0) begin
      bad++; $display("FAIL %s log_tied: got %0h/%0h/%0h want 0", tag, last_wadr, last_wdata, wr_count);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if ({ack, err, busy} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {ack, err, busy});
    end
    total++;
    if (readdata !== 32'd0) begin
      bad++; $display("FAIL reset_readdata: got %0h want 0", readdata);
    end
    clear_model();
    check_log("reset");
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_req(1'b1, 32'd84, 32'd7);
    run_req(1'b0, 32'd84, 32'd0);
  endtask

  task automatic test_back_to_back();
    int c;
    @(negedge clk);
    start_req(1'b1, 32'd80, 32'hDEADBEEF);
    wait_ack(c);
    finish_resp(c, 1'b0);
    start_req(1'b0, 32'd80, 32'd0);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept: got busy=%b want 1", busy);
    end
    wait_ack(c);
    finish_resp(c + 1, 1'b1);
  endtask

  task automatic test_misaligned();
    logic [15:0] cnt_before;
    cnt_before = wr_count;
    run_req(1'b1, 32'd82, 32'd5);
    run_req(1'b0, 32'd80, 32'd0);
    total++;
    if (wr_count !== cnt_before) begin
      bad++; $display("FAIL misaligned_wr_count: got %0d want %0d", wr_count, cnt_before);
    end
  endtask

  task automatic test_range();
    run_req(1'b0, 32'd256, 32'd0);
    run_req(1'b0, 32'd252, 32'd0);
    run_req(1'b0, 32'hFFFFFFFC, 32'd0);
    run_req(1'b1, 32'd256, 32'd1);
    run_req(1'b1, 32'd252, 32'h0BAD_F00D);
    run_req(1'b0, 32'd252, 32'd0);
    run_req(1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_ignore_fields();
    int c;
    @(negedge clk);
    start_req(1'b1, 32'd88, 32'h1234);
    @(negedge clk);
    dataadr   = 32'd92;
    writedata = 32'hFFFF_0000;
    memwrite  = 1'b0;
    wait_ack(c);
    finish_resp(c + 1, 1'b1);
    run_req(1'b0, 32'd88, 32'd0);
    run_req(1'b0, 32'd92, 32'd0);
  endtask

  task automatic test_reset_mid();
    exp_t dropped;
    run_req(1'b1, 32'd76, 32'd55);
    @(negedge clk);
    start_req(1'b1, 32'd84, 32'd9);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({busy, ack} !== 2'b00) begin
      bad++; $display("FAIL midreset_abort: got busy,ack=%b want 00", {busy, ack});
    end
    dropped = sb.pop_back();
    req = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (ack !== 1'b0) begin
      bad++; $display("FAIL midreset_noack adr=%0h: got %b want 0", dropped.adr, ack);
    end
    rst = 1'b1;
    clear_model();
    check_log("midreset");
    run_req(1'b0, 32'd84, 32'd0);
    run_req(1'b0, 32'd76, 32'd0);
  endtask

  task automatic test_random();
    logic        we;
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, DEPTH + 3)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'd2;
      run_req(we, a, $urandom);
    end
  endtask

  task automatic test_log();
    run_req(1'b1, 32'd84, 32'd7);
    run_req(1'b1, 32'd80, 32'd3);
    check_log("final");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_misaligned();
    test_range();
    test_ignore_fields();
    test_reset_mid();
    test_random();
    test_log();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
